// File: rtl/mem_port_arbiter_if.sv
// Bundles the two requester handshakes and the memory port signals of the
// shared 512x8 memory arbiter. slave = arbiter side, master = requesters + memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic              rvalid_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_b;
    logic              lock_b;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [ADDR_W-1:0] mem_raddr;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b, lock_b,
        input  mem_rdata,
        output gnt_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output mem_we, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b, lock_b,
        output mem_rdata,
        input  gnt_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  mem_we, mem_waddr, mem_wdata, mem_raddr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Per-port arbiter sharing one write port and one sync read port between the
// CPU (A) and the loader/debug port (B), with round-robin and a B-side lock.
//
// state     | meaning
// ST_IDLE   | per-port arbitration, round-robin on same-port contention
// ST_LOCK_B | B owns both ports, A is never granted
module mem_port_arbiter #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    mem_port_arbiter_if.slave bus,
    output logic             locked,
    output logic [CNT_W-1:0] conflict_cnt
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCK_B = 1'b1;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic              ptr_b;
    logic              contend;
    logic              gnt_a;
    logic              gnt_b;
    logic              wr_a;
    logic              wr_b;
    logic              rd_a;
    logic              rd_b;
    logic              rvalid_a_q;
    logic              rvalid_b_q;
    logic [ADDR_W-1:0] waddr_mux;
    logic [ADDR_W-1:0] raddr_mux;
    logic [DATA_W-1:0] wdata_mux;

    // Contention only exists when both requesters target the same memory port.
    always_comb begin
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        contend = 1'b0;
        if (!rst) begin
            if (state == ST_LOCK_B) begin
                gnt_b = bus.req_b;
            end else if (bus.req_a && bus.req_b && (bus.we_a == bus.we_b)) begin
                contend = 1'b1;
                gnt_a   = ~ptr_b;
                gnt_b   = ptr_b;
            end else begin
                gnt_a = bus.req_a;
                gnt_b = bus.req_b;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (gnt_b && bus.lock_b) state_nxt = ST_LOCK_B;
            ST_LOCK_B: if (!bus.lock_b)         state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign wr_a = gnt_a & bus.we_a;
    assign wr_b = gnt_b & bus.we_b;
    assign rd_a = gnt_a & ~bus.we_a;
    assign rd_b = gnt_b & ~bus.we_b;

    // Ungranted ports park at zero so the memory sees a quiet bus.
    always_comb begin
        waddr_mux = '0;
        wdata_mux = '0;
        raddr_mux = '0;
        if (wr_a) begin
            waddr_mux = bus.addr_a;
            wdata_mux = bus.wdata_a;
        end else if (wr_b) begin
            waddr_mux = bus.addr_b;
            wdata_mux = bus.wdata_b;
        end
        if (rd_a)      raddr_mux = bus.addr_a;
        else if (rd_b) raddr_mux = bus.addr_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            ptr_b        <= 1'b0;
            rvalid_a_q   <= 1'b0;
            rvalid_b_q   <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state      <= state_nxt;
            rvalid_a_q <= rd_a;
            rvalid_b_q <= rd_b;
            if (contend) begin
                ptr_b <= ~ptr_b;
                if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
            end else if ((state == ST_LOCK_B) && !bus.lock_b) begin
                ptr_b <= 1'b0;
            end
        end
    end

    assign bus.gnt_a     = gnt_a;
    assign bus.gnt_b     = gnt_b;
    assign bus.rvalid_a  = rvalid_a_q;
    assign bus.rvalid_b  = rvalid_b_q;
    assign bus.rdata_a   = bus.mem_rdata;
    assign bus.rdata_b   = bus.mem_rdata;
    assign bus.mem_we    = wr_a | wr_b;
    assign bus.mem_waddr = waddr_mux;
    assign bus.mem_wdata = wdata_mux;
    assign bus.mem_raddr = raddr_mux;
    assign locked        = (state == ST_LOCK_B);
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the 512x8 program/data memory (one write port, one synchronous read port, 1-cycle read latency) between two requesters: A (Lipsi CPU) and B (program loader / debug port).
- Sits between the requesters and the memory; drives all memory ports.
- Grants per memory port, so a read and a write from different requesters can issue in the same cycle.
- Supports round-robin on contention and a B-side exclusive lock for program download.

Parameters:
- ADDR_W, 9, address width (512-byte space)
- DATA_W, 8, data width
- CNT_W, 16, width of the contention counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_a  in  1  requester A access request
- we_a  in  1  A: 1 = write, 0 = read
- addr_a  in  ADDR_W  A address
- wdata_a  in  DATA_W  A write data
- gnt_a  out  1  A request accepted this cycle (combinational)
- rvalid_a  out  1  A read data valid (registered)
- rdata_a  out  DATA_W  A read data
- req_b, we_b, addr_b, wdata_b, gnt_b, rvalid_b, rdata_b: same as the A ports, for requester B
- lock_b  in  1  B requests exclusive ownership
- mem_we  out  1  memory write enable
- mem_waddr  out  ADDR_W  memory write address
- mem_wdata  out  DATA_W  memory write data
- mem_raddr  out  ADDR_W  memory read address
- mem_rdata  in  DATA_W  memory read data (valid the cycle after mem_raddr)
- locked  out  1  arbiter is in LOCK_B state
- conflict_cnt  out  CNT_W  saturating count of contention cycles

Behaviour:
- Reset (async, rst=1):
  - State IDLE; priority pointer = A.
  - rvalid_a/b = 0; conflict_cnt = 0; locked = 0.
  - gnt_a/b = 0 and mem_we = 0 while rst is high.
- Transfer: req_x & gnt_x in cycle N.
  - Write: mem_we = 1, with that requester's address and data, in cycle N.
  - Read: mem_raddr = that address in cycle N; rvalid_x = 1 in cycle N+1 only, with rdata_x = mem_rdata.
- Requester hold rule: a requester holds req/we/addr/wdata stable until granted.
- Idle port values:
  - No write granted: mem_we = 0, mem_waddr = 0, mem_wdata = 0.
  - No read granted: mem_raddr = 0.
- rdata_a/rdata_b mirror mem_rdata continuously; they are meaningful only when the matching rvalid is high.
- States: IDLE, LOCK_B.
- IDLE arbitration:
  - Requests for different ports (one read, one write): both granted.
  - Same port (read/read or write/write): the requester named by the pointer wins. The pointer then moves to the loser. conflict_cnt increments (saturates at all-ones).
  - Single request: granted. Pointer unchanged.
- IDLE -> LOCK_B: on a cycle with req_b & gnt_b & lock_b. That B access completes normally.
- LOCK_B:
  - gnt_a = 0 unconditionally, including the dual-issue case.
  - Every B request is granted.
  - A requests are not counted as conflicts.
  - locked = 1 (registered, equals state == LOCK_B).
- LOCK_B -> IDLE: the cycle after lock_b is sampled low. Pointer set to A on exit.
- Same-address read and write in one cycle: the read returns the old contents (memory read-before-write). The arbiter adds no forwarding.
- rst mid-operation: a pending rvalid is dropped (no rvalid after reset deassertion). Lock is released.

Test Plan:
- Reset, then A reads 0x000 with mem[0]=0xC7 -> gnt_a=1 same cycle; next cycle rvalid_a=1, rdata_a=0xC7, rvalid_b=0.
- A writes 0x101 data 0x0A while B reads 0x005 in the same cycle -> gnt_a=gnt_b=1, mem_we=1, mem_waddr=0x101, mem_raddr=0x005; rvalid_b next cycle; conflict_cnt stays 0.
- A and B both read every cycle for 4 cycles -> grants alternate A,B,A,B; conflict_cnt=4; each rvalid follows its grant by exactly one cycle.
- B writes 0x000=0xC7 with lock_b=1, then A requests reads for 3 cycles while B writes 0x001..0x003 -> locked=1 from the next cycle, gnt_a=0 throughout; after lock_b drops, the following cycle A is granted.
- conflict_cnt forced near max (CNT_W=4, 15 contention cycles then 3 more) -> holds at 0xF.
- rst asserted in the cycle after a granted A read -> rvalid_a=0 immediately; locked=0; pointer=A on next contention.
